keypad_scanner: RTL and testbench

- Upstream front end for the passcode controller.
- Drives the 4x4 keypad columns one-hot and samples the raw row lines through a synchronizer.
- Debounces press and release, then emits exactly one encoded key event per physical press.
- The passcode FSM consumes `key_code`/`key_valid` instead of decoding raw `row`/`col` itself.

---
 rtl/keypad_scanner.sv | 153 +++++++++++++++
 tb/tb_keypad_scanner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// 4x4 keypad front end: one-hot column scan, synchronized rows, press/release
// debounce, and a single encoded key event per physical press.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_RELEASE
   } state_t;

   state_t             r_state;
   logic [3:0]         r_sync1;
   logic [3:0]         r_row_s;
   logic [DIV_W-1:0]   r_div;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         r_cap_row;

   logic               w_row_onehot;
   logic [3:0]         w_col_next;
   logic [3:0]         w_code;

   // Column index 0 is the left column, row index 0 the top row.
   function automatic logic [3:0] encode_key(input logic [3:0] c, input logic [3:0] r);
      logic [1:0] ci;
      logic [1:0] ri;
      logic [3:0] code;
      ci   = 2'd0;
      ri   = 2'd0;
      code = 4'h0;
      case (c)
         4'b1000: ci = 2'd0;
         4'b0100: ci = 2'd1;
         4'b0010: ci = 2'd2;
         default: ci = 2'd3;
      endcase
      case (r)
         4'b1000: ri = 2'd0;
         4'b0100: ri = 2'd1;
         4'b0010: ri = 2'd2;
         default: ri = 2'd3;
      endcase
      if (ci == 2'd3) begin
         code = 4'hA + 4'(ri);
      end else if (ri == 2'd3) begin
         case (ci)
            2'd0:    code = 4'hE;
            2'd1:    code = 4'h0;
            default: code = 4'hF;
         endcase
      end else begin
         code = 4'(ri) * 4'd3 + 4'(ci) + 4'd1;
      end
      return code;
   endfunction

   assign w_row_onehot = (r_row_s != 4'b0000) && ((r_row_s & (r_row_s - 4'd1)) == 4'b0000);
   assign w_col_next   = {col[0], col[3:1]};
   assign w_code       = encode_key(col, r_cap_row);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_SCAN;
         r_sync1   <= 4'b0000;
         r_row_s   <= 4'b0000;
         r_div     <= '0;
         r_cnt     <= '0;
         r_cap_row <= 4'b0000;
         col       <= 4'b1000;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         r_sync1   <= row;
         r_row_s   <= r_sync1;
         key_valid <= 1'b0;
         case (r_state)
            ST_SCAN: begin
               if (r_div == DIV_LAST) begin
                  if (w_row_onehot) begin
                     r_cap_row <= r_row_s;
                     r_cnt     <= CNT_W'(1);
                     r_state   <= ST_DEBOUNCE;
                  end else begin
                     r_div <= '0;
                     col   <= w_col_next;
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end
            ST_DEBOUNCE: begin
               if (r_row_s == r_cap_row) begin
                  if (r_cnt == CNT_LAST) begin
                     r_state   <= ST_HELD;
                     r_cnt     <= '0;
                     key_code  <= w_code;
                     key_valid <= 1'b1;
                     key_held  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end else begin
                  // Bounce during acceptance: abandon and move on to the next column.
                  r_state <= ST_SCAN;
                  r_cnt   <= '0;
                  r_div   <= '0;
                  col     <= w_col_next;
               end
            end
            ST_HELD: begin
               if (r_row_s == 4'b0000) begin
                  r_state <= ST_RELEASE;
                  r_cnt   <= CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (r_row_s != 4'b0000) begin
                  r_state <= ST_HELD;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state  <= ST_SCAN;
                  r_cnt    <= '0;
                  r_div    <= '0;
                  col      <= w_col_next;
                  key_held <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= ST_SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Bench for keypad_scanner: a keypad model drives rows from the scanned column;
// expected key codes are queued at press time and matched against key_valid strobes.
module tb_keypad_scanner;

   logic       clk;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [3:0] kp [4];
   logic [3:0] exp_q [$];
   logic [3:0] last_code;
   int         errors;
   int         checks;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a pressed key connects its row only while its column is driven.
   assign row = (col[3] ? kp[0] : 4'b0000) | (col[2] ? kp[1] : 4'b0000) |
                (col[1] ? kp[2] : 4'b0000) | (col[0] ? kp[3] : 4'b0000);

   function automatic logic [3:0] col_of(input int idx);
      logic [3:0] base;
      base = 4'b1000;
      return base >> (idx % 4);
   endfunction

   // Scoreboard: every strobe must match the oldest queued press; code must not move otherwise.
   always @(negedge clk) begin
      logic [3:0] exp_code;
      if (rst === 1'b0) last_code = 4'h0;
      checks++;
      if (key_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: key_valid with key_code=%h, nothing expected", key_code);
         end else begin
            exp_code = exp_q.pop_front();
            if (key_code !== exp_code) begin
               errors++;
               $display("FAIL event_code: got %h expected %h", key_code, exp_code);
            end
         end
         last_code = key_code;
      end else if (key_code !== last_code) begin
         errors++;
         $display("FAIL code_stable: key_code=%h changed without key_valid, expected %h", key_code, last_code);
      end
   end

   task automatic wait_valid(input int bound, output bit found);
      found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (key_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_unheld(input int bound, output bit done);
      done = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (key_held === 1'b0) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_col(input logic [3:0] target, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (col === target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic press_key(input int cidx, input logic [3:0] rowv, input logic [3:0] code,
                            input int hold);
      bit found;
      int bad;
      exp_q.push_back(code);
      kp[cidx] = rowv;
      wait_valid(64, found);
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL press_timeout: no key_valid for key %h, expected one", code);
      end
      checks++;
      if (key_held !== 1'b1 || col !== col_of(cidx)) begin
         errors++;
         $display("FAIL press_accept: key_held=%b col=%b, expected 1 and %b", key_held, col, col_of(cidx));
      end
      bad = 0;
      repeat (hold) begin
         @(negedge clk);
         if (key_held !== 1'b1 || col !== col_of(cidx) || key_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_%h: %0d bad cycles, expected 0", code, bad);
      end
      kp[cidx] = 4'b0000;
      wait_unheld(32, found);
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL release_timeout: key_held stuck at %b, expected 0", key_held);
      end
      checks++;
      if (col !== col_of(cidx + 1)) begin
         errors++;
         $display("FAIL release_col: col=%b, expected %b", col, col_of(cidx + 1));
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (col !== 4'b1000 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
         errors++;
         $display("FAIL reset_state: col=%b valid=%b held=%b code=%h, expected 1000 0 0 0",
                  col, key_valid, key_held, key_code);
      end
      #2 rst = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) @(negedge clk);
         checks++;
         if (col !== col_of(k / 4)) begin
            errors++;
            $display("FAIL scan_seq_%0d: col=%b, expected %b", k, col, col_of(k / 4));
         end
      end
   endtask

   task automatic test_sequence();
      press_key(0, 4'b1000, 4'h1, 12);
      press_key(1, 4'b0010, 4'h8, 12);
      press_key(2, 4'b0100, 4'h6, 12);
      press_key(1, 4'b0100, 4'h5, 12);
   endtask

   task automatic test_bounce();
      bit ok;
      int vcount;
      wait_col(4'b1000, 32, ok);
      kp[1] = 4'b0100;
      wait_col(4'b0100, 32, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bounce_col_timeout: col=%b, expected 0100", col);
      end
      vcount = 0;
      repeat (3) begin @(negedge clk); if (key_valid === 1'b1) vcount++; end
      kp[1] = 4'b0000;
      repeat (2) begin @(negedge clk); if (key_valid === 1'b1) vcount++; end
      kp[1] = 4'b0100;
      @(negedge clk);
      if (key_valid === 1'b1) vcount++;
      checks++;
      if (col !== 4'b0010 || key_held !== 1'b0 || vcount != 0) begin
         errors++;
         $display("FAIL bounce_abort: col=%b held=%b strobes=%0d, expected 0010 0 0", col, key_held, vcount);
      end
      press_key(1, 4'b0100, 4'h5, 4);
   endtask

   task automatic test_long_hold();
      press_key(3, 4'b0001, 4'hD, 100);
   endtask

   task automatic test_multikey();
      logic [3:0] prev;
      int changes;
      int held_bad;
      kp[0] = 4'b1100;
      prev = col;
      changes = 0;
      held_bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (col !== prev) changes++;
         if (key_held !== 1'b0) held_bad++;
         prev = col;
      end
      kp[0] = 4'b0000;
      checks++;
      if (changes != 10 || held_bad != 0) begin
         errors++;
         $display("FAIL multikey: col changes=%0d held cycles=%0d, expected 10 and 0", changes, held_bad);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit found;
      exp_q.push_back(4'h6);
      kp[2] = 4'b0100;
      wait_valid(64, found);
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL midreset_press: no key_valid, expected one");
      end
      repeat (5) @(negedge clk);
      checks++;
      if (key_held !== 1'b1) begin
         errors++;
         $display("FAIL midreset_held: key_held=%b, expected 1", key_held);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (col !== 4'b1000 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
         errors++;
         $display("FAIL midreset_async: col=%b valid=%b held=%b code=%h, expected 1000 0 0 0",
                  col, key_valid, key_held, key_code);
      end
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      exp_q.push_back(4'h6);
      wait_valid(64, found);
      checks++;
      if (!found || col !== 4'b0010) begin
         errors++;
         $display("FAIL midreset_repress: found=%b col=%b, expected 1 and 0010", found, col);
      end
      kp[2] = 4'b0000;
      wait_unheld(32, found);
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL midreset_release: key_held=%b, expected 0", key_held);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      errors    = 0;
      checks    = 0;
      last_code = 4'h0;
      for (int i = 0; i < 4; i++) kp[i] = 4'b0000;
      test_reset();
      test_sequence();
      test_bounce();
      test_long_hold();
      test_multikey();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
